// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state type, header field positions and round-robin pick for the read arbiter
package router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        HDR_WT = 2'd2,
        BODY   = 2'd3
    } arb_state_t;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    // First requesting channel strictly after 'last', wrapping 2 -> 0.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/router_egress_queue.sv
// rtl/router_egress_queue.sv - two-entry egress FIFO carrying byte, sop/eop tags and source channel
module router_egress_queue #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_sop,
    input  logic              push_eop,
    input  logic [1:0]        push_chan,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [1:0]        out_chan,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] data_mem [2];
    logic [1:0]        chan_mem [2];
    logic [1:0]        sop_mem;
    logic [1:0]        eop_mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign out_valid = (count != 2'd0);
    assign do_pop    = pop && out_valid;
    assign do_push   = push && ((count != 2'd2) || do_pop);

    // Head entry is read straight from storage so it holds steady under backpressure.
    assign out_data  = data_mem[rd_ptr];
    assign out_sop   = sop_mem[rd_ptr];
    assign out_eop   = eop_mem[rd_ptr];
    assign out_chan  = chan_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                chan_mem[i] <= 2'd0;
            end
            sop_mem <= 2'b00;
            eop_mem <= 2'b00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                data_mem[wr_ptr] <= push_data;
                chan_mem[wr_ptr] <= push_chan;
                sop_mem[wr_ptr]  <= push_sop;
                eop_mem[wr_ptr]  <= push_eop;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_read_arbiter.sv
// rtl/router_read_arbiter.sv - round-robin packet-locked drain of three router FIFOs onto one egress stream
module router_read_arbiter
    import router_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STALL_LIMIT = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        valid_out,
    input  logic [DATA_W-1:0] data_out_0,
    input  logic [DATA_W-1:0] data_out_1,
    input  logic [DATA_W-1:0] data_out_2,
    output logic [2:0]        read_en,
    input  logic              eg_ready,
    output logic              eg_valid,
    output logic [DATA_W-1:0] eg_data,
    output logic              eg_sop,
    output logic              eg_eop,
    output logic [1:0]        eg_chan,
    output logic              eg_abort
);

    localparam int REM_W   = LEN_W + 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    arb_state_t        state;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_next;
    logic [1:0]        grant;
    logic [REM_W-1:0]  remaining;
    logic [STALL_W-1:0] stall_cnt;
    logic              rd_pending;
    logic [1:0]        rd_chan;
    logic              rd_sop;
    logic              rd_eop;
    logic              abort_q;
    logic [DATA_W-1:0] rd_data;
    logic              chan_valid;
    logic              want_read;
    logic              credit;
    logic              rd_fire;
    logic              stall_tick;
    logic              stall_hit;
    logic [1:0]        q_count;
    logic [1:0]        q_chan;
    logic              q_pop;

    always_comb begin
        case (rd_chan)
            2'd0:    rd_data = data_out_0;
            2'd1:    rd_data = data_out_1;
            default: rd_data = data_out_2;
        endcase
        case (grant)
            2'd0:    chan_valid = valid_out[0];
            2'd1:    chan_valid = valid_out[1];
            default: chan_valid = valid_out[2];
        endcase
    end

    assign rr_next    = rr_pick(rr_ptr, valid_out);
    assign want_read  = (state == HDR) || ((state == BODY) && (remaining != '0));
    // A byte in flight from the FIFO already owns a queue slot.
    assign credit     = (q_count + {1'b0, rd_pending}) < 2'd2;
    assign rd_fire    = want_read && credit && chan_valid && !reset;
    assign read_en    = rd_fire ? (3'b001 << grant) : 3'b000;
    assign stall_tick = want_read && !chan_valid;
    assign stall_hit  = stall_tick && (stall_cnt == STALL_W'(STALL_LIMIT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 2'd2;
            grant      <= 2'd0;
            remaining  <= '0;
            stall_cnt  <= '0;
            rd_pending <= 1'b0;
            rd_chan    <= 2'd0;
            rd_sop     <= 1'b0;
            rd_eop     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            abort_q    <= 1'b0;
            rd_pending <= rd_fire;
            if (rd_fire) begin
                rd_chan   <= grant;
                rd_sop    <= (state == HDR);
                rd_eop    <= (state == BODY) && (remaining == REM_W'(1));
                stall_cnt <= '0;
            end else if (stall_hit) begin
                stall_cnt <= '0;
                abort_q   <= 1'b1;
            end else if (stall_tick) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            case (state)
                IDLE: begin
                    if (|valid_out) begin
                        grant  <= rr_next;
                        rr_ptr <= rr_next;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    if (rd_fire) begin
                        state <= HDR_WT;
                    end else if (stall_hit) begin
                        state <= IDLE;
                    end
                end
                HDR_WT: begin
                    // Payload plus the trailing parity byte.
                    remaining <= {1'b0, rd_data[LEN_MSB:LEN_LSB]} + REM_W'(1);
                    state     <= BODY;
                end
                BODY: begin
                    if (rd_fire) begin
                        remaining <= remaining - REM_W'(1);
                    end else if (stall_hit) begin
                        state <= IDLE;
                    end else if ((remaining == '0) && !rd_pending) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q_pop = eg_valid && eg_ready;

    router_egress_queue #(
        .DATA_W(DATA_W)
    ) u_egress_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (rd_pending),
        .push_data (rd_data),
        .push_sop  (rd_sop),
        .push_eop  (rd_eop),
        .push_chan (rd_chan),
        .pop       (q_pop),
        .out_valid (eg_valid),
        .out_data  (eg_data),
        .out_sop   (eg_sop),
        .out_eop   (eg_eop),
        .out_chan  (q_chan),
        .count     (q_count)
    );

    // During the abort pulse eg_chan names the truncated channel.
    assign eg_chan  = abort_q ? grant : q_chan;
    assign eg_abort = abort_q;

endmodule

// File: tb/tb_router_read_arbiter.sv
// tb/tb_router_read_arbiter.sv - self-checking bench with FIFO emulation and packet-level scoreboard
module tb_router_read_arbiter;

    localparam int DATA_W      = 8;
    localparam int STALL_LIMIT = 24;

    logic              clock = 1'b0;
    logic              reset;
    logic [2:0]        valid_out;
    logic [DATA_W-1:0] data_out_0;
    logic [DATA_W-1:0] data_out_1;
    logic [DATA_W-1:0] data_out_2;
    logic [2:0]        read_en;
    logic              eg_ready;
    logic              eg_valid;
    logic [DATA_W-1:0] eg_data;
    logic              eg_sop;
    logic              eg_eop;
    logic [1:0]        eg_chan;
    logic              eg_abort;

    router_read_arbiter #(
        .DATA_W      (DATA_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_out  (valid_out),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .read_en    (read_en),
        .eg_ready   (eg_ready),
        .eg_valid   (eg_valid),
        .eg_data    (eg_data),
        .eg_sop     (eg_sop),
        .eg_eop     (eg_eop),
        .eg_chan    (eg_chan),
        .eg_abort   (eg_abort)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] b;
    } ent_t;

    ent_t       fifo_q [$];
    ent_t       exp_q [$];
    int         sop_log [$];
    int         pos [3];
    int         total [3];
    int         last_rd [3];
    int         active_ch;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         bytes_out = 0;
    int         rd_count = 0;
    int         abort_cnt = 0;
    int         abort_cyc = 0;
    int         first_rd;
    int         first_v;
    int         ready_mode;
    logic [1:0] abort_ch;
    logic [2:0] rd_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    function automatic int fifo_cnt(input int c);
        int n = 0;
        foreach (fifo_q[i]) if (fifo_q[i].ch == 2'(c)) n++;
        return n;
    endfunction

    function automatic logic [8:0] fifo_take(input int c);
        logic [8:0] r;
        r = 9'h000;
        for (int i = 0; i < fifo_q.size(); i++) begin
            if (fifo_q[i].ch == 2'(c)) begin
                r = {1'b1, fifo_q[i].b};
                fifo_q.delete(i);
                break;
            end
        end
        return r;
    endfunction

    function automatic logic [8:0] exp_take(input int c);
        logic [8:0] r;
        r = 9'h000;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].ch == 2'(c)) begin
                r = {1'b1, exp_q[i].b};
                exp_q.delete(i);
                break;
            end
        end
        return r;
    endfunction

    task automatic push_byte(input int c, input logic [7:0] b);
        ent_t e;
        e.ch = 2'(c);
        e.b  = b;
        fifo_q.push_back(e);
        exp_q.push_back(e);
    endtask

    task automatic push_pkt(input int c, input int len);
        push_byte(c, {6'(len), 2'($urandom)});
        for (int i = 0; i < len; i++) push_byte(c, 8'($urandom));
        push_byte(c, 8'($urandom));
    endtask

    task automatic flush_model();
        fifo_q.delete();
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            pos[c]   = 0;
            total[c] = 0;
        end
        active_ch = -1;
        rd_prev   = 3'b000;
    endtask

    task automatic egress();
        logic [8:0] t;
        int         c;
        logic       want_sop;
        logic       want_eop;
        c = int'(eg_chan);
        if (active_ch >= 0) check("chan_locked", 32'(eg_chan), active_ch);
        t = exp_take(c);
        check("byte_expected", 32'(t[8]), 1);
        check("eg_data", 32'(eg_data), 32'(t[7:0]));
        if (pos[c] == 0) total[c] = int'(t[7:2]) + 2;
        want_sop = (pos[c] == 0);
        want_eop = (pos[c] == total[c] - 1);
        check("eg_sop", 32'(eg_sop), 32'(want_sop));
        check("eg_eop", 32'(eg_eop), 32'(want_eop));
        if (want_sop) sop_log.push_back(c);
        bytes_out++;
        if (want_eop) begin
            pos[c]    = 0;
            active_ch = -1;
        end else begin
            pos[c]++;
            active_ch = c;
        end
    endtask

    // One clock: emulate FIFO read latency, drive inputs, then observe outputs mid-cycle.
    task automatic tick();
        logic [8:0] t;
        logic [7:0] d [3];
        @(posedge clock);
        #1;
        cyc++;
        for (int c = 0; c < 3; c++) begin
            d[c] = 8'($urandom);
            if (rd_prev[c]) begin
                t = fifo_take(c);
                check("read_hits_data", 32'(t[8]), 1);
                d[c] = t[7:0];
            end
        end
        data_out_0 = d[0];
        data_out_1 = d[1];
        data_out_2 = d[2];
        for (int c = 0; c < 3; c++) valid_out[c] = (fifo_cnt(c) != 0);
        case (ready_mode)
            0:       eg_ready = 1'b0;
            1:       eg_ready = 1'b1;
            default: eg_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        if (read_en != 3'b000) begin
            check("read_en_onehot", $countones(read_en), 1);
            check("read_en_on_valid", 32'(read_en & ~valid_out), 0);
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
            for (int c = 0; c < 3; c++) if (read_en[c]) last_rd[c] = cyc;
        end
        rd_prev = read_en;
        if (eg_valid && first_v < 0) first_v = cyc;
        if (eg_valid && eg_ready) egress();
        if (eg_abort) begin
            abort_cnt++;
            abort_ch      = eg_chan;
            abort_cyc     = cyc;
            pos[eg_chan]  = 0;
            active_ch     = -1;
        end
    endtask

    task automatic run_bytes(input int target, input int budget, input string tag);
        int n = 0;
        while (bytes_out < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bytes_out >= target), 1);
    endtask

    initial begin
        int b0;
        int b1;
        int r0;
        int r1;
        int r2;
        int a0;
        int n;
        int tgt;
        int exp_order [5];

        reset      = 1'b1;
        valid_out  = 3'b000;
        data_out_0 = '0;
        data_out_1 = '0;
        data_out_2 = '0;
        eg_ready   = 1'b0;
        ready_mode = 0;
        first_rd   = -1;
        first_v    = -1;
        flush_model();
        for (int c = 0; c < 3; c++) last_rd[c] = 0;

        tick();
        tick();
        check("rst_read_en", 32'(read_en), 0);
        check("rst_eg_valid", 32'(eg_valid), 0);
        check("rst_eg_data", 32'(eg_data), 0);
        check("rst_eg_sop", 32'(eg_sop), 0);
        check("rst_eg_eop", 32'(eg_eop), 0);
        check("rst_eg_chan", 32'(eg_chan), 0);
        check("rst_eg_abort", 32'(eg_abort), 0);

        // All channels requesting at reset release; ch0 and ch1 hold a second packet.
        push_pkt(0, $urandom_range(0, 6));
        push_pkt(1, $urandom_range(0, 6));
        push_pkt(2, $urandom_range(0, 6));
        push_pkt(0, $urandom_range(0, 6));
        push_pkt(1, $urandom_range(0, 6));
        b0  = bytes_out;
        tgt = exp_q.size();
        ready_mode = 2;
        reset = 1'b0;
        run_bytes(b0 + tgt, 400, "t2_drain");
        exp_order = '{0, 1, 2, 0, 1};
        check("t2_pkt_count", sop_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < sop_log.size()) check("t2_rr_order", sop_log[i], exp_order[i]);

        ready_mode = 1;
        repeat (3) tick();
        first_rd = -1;
        first_v  = -1;
        b0 = bytes_out;
        push_byte(1, 8'h0D);
        repeat (4) push_byte(1, 8'($urandom));
        run_bytes(b0 + 5, 60, "t1_done");
        check("t1_latency", first_v - first_rd, 2);
        check("t1_chan", sop_log[sop_log.size() - 1], 1);

        b0 = bytes_out;
        push_pkt(0, 20);
        run_bytes(b0 + 4, 60, "t3_start");
        ready_mode = 0;
        b1 = bytes_out;
        r0 = rd_count;
        repeat (5) tick();
        r1 = rd_count;
        repeat (5) tick();
        r2 = rd_count;
        check("t3_bp_reads", 32'((r2 - r0) <= 2), 1);
        check("t3_bp_stopped", r2 - r1, 0);
        check("t3_no_out", bytes_out, b1);
        ready_mode = 2;
        run_bytes(b0 + 22, 200, "t3_done");

        ready_mode = 1;
        repeat (3) tick();
        b0 = bytes_out;
        a0 = abort_cnt;
        push_byte(2, {6'd5, 2'b01});
        push_byte(2, 8'($urandom));
        push_byte(2, 8'($urandom));
        n = 0;
        while (abort_cnt == a0 && n < 80) begin
            tick();
            n++;
        end
        check("t4_abort_seen", abort_cnt - a0, 1);
        check("t4_abort_chan", 32'(abort_ch), 2);
        check("t4_abort_timing", abort_cyc - last_rd[2], STALL_LIMIT + 1);
        check("t4_bytes", bytes_out - b0, 3);
        repeat (5) tick();
        check("t4_single_pulse", abort_cnt - a0, 1);

        b0 = bytes_out;
        push_byte(2, 8'h02);
        push_byte(2, 8'($urandom));
        run_bytes(b0 + 2, 40, "t5_len0");
        repeat (4) tick();
        check("t5_len0_count", bytes_out - b0, 2);
        b0 = bytes_out;
        ready_mode = 2;
        push_pkt(2, 63);
        run_bytes(b0 + 65, 600, "t5_len63");
        repeat (4) tick();
        check("t5_len63_count", bytes_out - b0, 65);
        check("t5_model_empty", exp_q.size(), 0);

        ready_mode = 1;
        b0 = bytes_out;
        push_pkt(1, 30);
        run_bytes(b0 + 3, 60, "t6_in_body");
        reset = 1'b1;
        tick();
        check("t6_read_en", 32'(read_en), 0);
        check("t6_eg_valid", 32'(eg_valid), 0);
        check("t6_eg_sop", 32'(eg_sop), 0);
        check("t6_eg_abort", 32'(eg_abort), 0);
        flush_model();
        sop_log.delete();
        push_pkt(1, $urandom_range(0, 8));
        push_pkt(2, $urandom_range(0, 8));
        push_pkt(0, $urandom_range(0, 8));
        b0  = bytes_out;
        tgt = exp_q.size();
        tick();
        reset = 1'b0;
        run_bytes(b0 + tgt, 300, "t6_drain");
        check("t6_pkt_count", sop_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < sop_log.size()) check("t6_rr_after_reset", sop_log[i], i);
        repeat (4) tick();
        check("final_fifo_empty", fifo_q.size(), 0);
        check("final_model_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
